emb_pkt_fifo: RTL and testbench

Parametrised single-clock frame FIFO for the Ethernet MAC datapath, built on a simple-dual-port embedded RAM with synchronous read.
Writes are tentative until the frame is committed. An abort, or an overflow inside a frame, rewinds the write pointer so the whole bad frame is dropped.
The reader only ever sees committed frames. The block sits between the RX MAC framer and the host-side DMA/bus bridge.

---
 rtl/emb_pkt_fifo_pkg.sv | 46 ++++
 rtl/emb_sdp_ram.sv | 53 +++++
 rtl/emb_pkt_fifo.sv | 149 ++++++++++++++
 tb/tb_emb_pkt_fifo.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/emb_pkt_fifo_pkg.sv
//------------------------------------------------------------------------------
// Module   : emb_pkt_fifo_pkg
// Brief    : Shared helpers for the frame FIFO: pointer width, level/free
//            arithmetic, parity and RAM width selection.
//            Honours ETH_PKT_FIFO_PARITY_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package emb_pkt_fifo_pkg;

    localparam int C_MAX_PW = 33;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    function automatic int ptr_width(input int aw);
        return aw + 1;
    endfunction

    function automatic logic [C_MAX_PW-1:0] ptr_diff(input logic [C_MAX_PW-1:0] a,
                                                     input logic [C_MAX_PW-1:0] b,
                                                     input int                  pw);
        logic [C_MAX_PW-1:0] mask;
        mask = (C_MAX_PW'(1) << pw) - C_MAX_PW'(1);
        return (a - b) & mask;
    endfunction

    function automatic logic [C_MAX_PW-1:0] free_words(input logic [C_MAX_PW-1:0] level,
                                                       input int                  aw);
        return (C_MAX_PW'(1) << aw) - level;
    endfunction

    function automatic logic even_parity(input logic [31:0] d);
        return ^d;
    endfunction

    function automatic int ram_width(input int dw);
`ifdef ETH_PKT_FIFO_PARITY_EN
        return dw + 1;
`else
        return dw;
`endif
    endfunction

endpackage

`default_nettype wire

// File: rtl/emb_sdp_ram.sv
//------------------------------------------------------------------------------
// Module   : emb_sdp_ram
// Brief    : Simple-dual-port RAM, one write port and a registered read port on
//            one clock, no write-through. Infers EMB5K blocks at 256x16 class.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module emb_sdp_ram #(
    parameter int W  = 16,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem_q [2**AW];
    logic [W-1:0] rdata_d;
    logic [W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Output register holds its value between reads.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/emb_pkt_fifo.sv
//------------------------------------------------------------------------------
// Module   : emb_pkt_fifo
// Brief    : Single-clock frame FIFO with commit/abort; readers see committed
//            frames only. Optional parity via ETH_PKT_FIFO_PARITY_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module emb_pkt_fifo
    import emb_pkt_fifo_pkg::*;
#(
    parameter int DW        = 16,
    parameter int AW        = 8,
    parameter int AF_MARGIN = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          wr_commit,
    input  logic          wr_abort,
    output logic          full,
    output logic          almost_full,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          rd_perr,
    output logic          empty,
    output logic [AW:0]   rd_level,
    output logic [AW:0]   wr_level,
    output logic          drop
);

    localparam int PW    = ptr_width(AW);
    localparam int RW    = ram_width(DW);
    localparam int DEPTH = 2**AW;

    logic [PW-1:0] wr_ptr_q,  wr_ptr_d;
    logic [PW-1:0] cmt_ptr_q, cmt_ptr_d;
    logic [PW-1:0] rd_ptr_q,  rd_ptr_d;
    logic          ovf_q,      ovf_d;
    logic          drop_q,     drop_d;
    logic          rd_valid_q, rd_valid_d;

    logic [PW-1:0] w_wr_level;
    logic [PW-1:0] w_rd_level;
    logic [PW-1:0] w_free;
    logic          w_full;
    logic          w_empty;
    logic          w_wr_acc;
    logic          w_rd_acc;
    logic          w_ovf_eff;
    logic [RW-1:0] w_ram_wdata;
    logic [RW-1:0] w_ram_rdata;

    assign w_wr_level = PW'(ptr_diff(C_MAX_PW'(wr_ptr_q),  C_MAX_PW'(rd_ptr_q), PW));
    assign w_rd_level = PW'(ptr_diff(C_MAX_PW'(cmt_ptr_q), C_MAX_PW'(rd_ptr_q), PW));
    assign w_free     = PW'(free_words(C_MAX_PW'(w_wr_level), AW));
    assign w_full     = (w_wr_level == PW'(DEPTH));
    assign w_empty    = (rd_ptr_q == cmt_ptr_q);
    assign w_wr_acc   = wr_en & ~w_full & ~wr_abort;
    assign w_rd_acc   = rd_en & ~w_empty;
    // A word rejected this cycle poisons the frame even if it commits now.
    assign w_ovf_eff  = ovf_q | (wr_en & w_full);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        cmt_ptr_d  = cmt_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        ovf_d      = ovf_q;
        drop_d     = 1'b0;
        rd_valid_d = w_rd_acc;
        if (w_rd_acc) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (wr_abort) begin
            wr_ptr_d = cmt_ptr_q;
            ovf_d    = 1'b0;
            drop_d   = 1'b1;
        end else begin
            if (w_wr_acc) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (wr_commit) begin
                ovf_d = 1'b0;
                if (w_ovf_eff) begin
                    wr_ptr_d = cmt_ptr_q;
                    drop_d   = 1'b1;
                end else begin
                    cmt_ptr_d = wr_ptr_d;
                end
            end else begin
                ovf_d = w_ovf_eff;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            cmt_ptr_q  <= '0;
            rd_ptr_q   <= '0;
            ovf_q      <= 1'b0;
            drop_q     <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            cmt_ptr_q  <= cmt_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ovf_q      <= ovf_d;
            drop_q     <= drop_d;
            rd_valid_q <= rd_valid_d;
        end
    end

`ifdef ETH_PKT_FIFO_PARITY_EN
    assign w_ram_wdata = {even_parity(32'(wr_data)), wr_data};
    assign rd_perr     = rd_valid_q & (^w_ram_rdata);
`else
    assign w_ram_wdata = wr_data;
    assign rd_perr     = 1'b0;
`endif

    emb_sdp_ram #(
        .W  (RW),
        .AW (AW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (w_wr_acc),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (w_ram_wdata),
        .re    (w_rd_acc),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (w_ram_rdata)
    );

    assign rd_data     = w_ram_rdata[DW-1:0];
    assign rd_valid    = rd_valid_q;
    assign drop        = drop_q;
    assign full        = w_full;
    assign empty       = w_empty;
    assign almost_full = (w_free <= PW'(AF_MARGIN));
    assign rd_level    = w_rd_level;
    assign wr_level    = w_wr_level;

endmodule

`default_nettype wire

// File: tb/tb_emb_pkt_fifo.sv
//------------------------------------------------------------------------------
// Module   : tb_emb_pkt_fifo
// Brief    : Self-checking bench for emb_pkt_fifo against a queue-based frame
//            model. Parity scenario compiled under ETH_PKT_FIFO_PARITY_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_emb_pkt_fifo;

    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int AFM   = 4;
    localparam int DEPTH = 2**AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_commit = 1'b0;
    logic          wr_abort = 1'b0;
    logic          rd_en = 1'b0;
    logic          full, almost_full, rd_valid, rd_perr, empty, drop;
    logic [DW-1:0] rd_data;
    logic [AW:0]   rd_level, wr_level;

    int checks = 0;
    int errors = 0;

    // Model: committed words, pending frame words, frame overflow flag.
    logic [DW-1:0] cq[$];
    logic [DW-1:0] fq[$];
    bit            m_ovf;
    bit            m_valid;
    bit            m_drop;
    logic [DW-1:0] m_rdata;

    emb_pkt_fifo #(.DW(DW), .AW(AW), .AF_MARGIN(AFM)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .wr_commit   (wr_commit),
        .wr_abort    (wr_abort),
        .full        (full),
        .almost_full (almost_full),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .rd_perr     (rd_perr),
        .empty       (empty),
        .rd_level    (rd_level),
        .wr_level    (wr_level),
        .drop        (drop)
    );

    always #5 clk = ~clk;

    // One clock with the given inputs; model advances on the same edge.
    task automatic tick(input bit we, input logic [DW-1:0] wd, input bit wc,
                        input bit wa, input bit re);
        bit m_full, m_empty, wacc, ovf_eff;
        wr_en = we; wr_data = wd; wr_commit = wc; wr_abort = wa; rd_en = re;
        @(posedge clk);
        #1;
        wr_en = 1'b0; wr_commit = 1'b0; wr_abort = 1'b0; rd_en = 1'b0;
        m_full  = (cq.size() + fq.size()) == DEPTH;
        m_empty = (cq.size() == 0);
        m_valid = re && !m_empty;
        if (m_valid) m_rdata = cq.pop_front();
        m_drop  = 1'b0;
        wacc    = we && !m_full && !wa;
        ovf_eff = m_ovf || (we && m_full);
        if (wa) begin
            fq.delete(); m_ovf = 1'b0; m_drop = 1'b1;
        end else begin
            if (wacc) fq.push_back(wd);
            if (wc) begin
                if (ovf_eff) begin
                    fq.delete(); m_drop = 1'b1;
                end else begin
                    foreach (fq[i]) cq.push_back(fq[i]);
                    fq.delete();
                end
                m_ovf = 1'b0;
            end else begin
                m_ovf = ovf_eff;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        cq.delete(); fq.delete();
        m_ovf = 0; m_valid = 0; m_drop = 0; m_rdata = '0;
        checks++; if (empty !== 1'b1)  begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
        checks++; if (full !== 1'b0)   begin errors++; $display("FAIL reset_full got %b exp 0", full); end
        checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_af got %b exp 0", almost_full); end
        checks++; if (rd_level !== '0 || wr_level !== '0) begin errors++; $display("FAIL reset_levels got %0d/%0d exp 0/0", rd_level, wr_level); end
        checks++; if (rd_valid !== 1'b0 || drop !== 1'b0 || rd_perr !== 1'b0) begin errors++; $display("FAIL reset_pulses got v%b d%b p%b exp 0", rd_valid, drop, rd_perr); end
        checks++; if (rd_data !== '0)  begin errors++; $display("FAIL reset_rd_data got %h exp 0", rd_data); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        for (int i = 1; i <= 5; i++) tick(1, DW'(i), i == 5, 0, 0);
        checks++; if (rd_level !== 5'd5 || empty !== 1'b0) begin errors++; $display("FAIL basic_commit got lvl %0d empty %b exp 5 0", rd_level, empty); end
        for (int i = 1; i <= 4; i++) begin
            tick(0, '0, 0, 0, 1);
            checks++; if (rd_valid !== 1'b1 || rd_data !== DW'(i)) begin errors++; $display("FAIL basic_read%0d got v%b %h exp v1 %h", i, rd_valid, rd_data, DW'(i)); end
            checks++; if (rd_level !== 5'(5 - i)) begin errors++; $display("FAIL basic_level%0d got %0d exp %0d", i, rd_level, 5 - i); end
        end
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL basic_empty got %b exp 0", empty); end
        tick(0, '0, 0, 0, 1);
        tick(0, '0, 0, 0, 1);
        checks++; if (rd_valid !== 1'b0 || rd_data !== 16'h0005) begin errors++; $display("FAIL basic_empty_read got v%b %h exp v0 0005", rd_valid, rd_data); end
    endtask

    task automatic test_abort();
        for (int i = 0; i < 3; i++) tick(1, 16'hA000 + DW'(i), 0, 0, 0);
        checks++; if (empty !== 1'b1 || wr_level !== 5'd3) begin errors++; $display("FAIL abort_pending got empty %b wl %0d exp 1 3", empty, wr_level); end
        tick(1, 16'hDEAD, 0, 1, 0);
        checks++; if (wr_level !== 5'd0 || drop !== 1'b1) begin errors++; $display("FAIL abort_drop got wl %0d drop %b exp 0 1", wr_level, drop); end
        tick(0, '0, 0, 0, 0);
        checks++; if (drop !== 1'b0) begin errors++; $display("FAIL abort_drop_once got %b exp 0", drop); end
        tick(1, 16'hBEEF, 1, 0, 0);
        tick(0, '0, 0, 0, 1);
        checks++; if (rd_valid !== 1'b1 || rd_data !== 16'hBEEF) begin errors++; $display("FAIL abort_next_frame got v%b %h exp v1 beef", rd_valid, rd_data); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH; i++) tick(1, DW'(i), 0, 0, 0);
        checks++; if (full !== 1'b1 || almost_full !== 1'b1) begin errors++; $display("FAIL ovf_full got f%b af%b exp 1 1", full, almost_full); end
        tick(1, 16'h1717, 0, 0, 0);
        checks++; if (wr_level !== 5'(DEPTH)) begin errors++; $display("FAIL ovf_17th got wl %0d exp %0d", wr_level, DEPTH); end
        tick(0, '0, 1, 0, 0);
        checks++; if (drop !== 1'b1 || rd_level !== '0 || wr_level !== '0) begin errors++; $display("FAIL ovf_commit got d%b rl %0d wl %0d exp 1 0 0", drop, rd_level, wr_level); end
    endtask

    task automatic test_commit_abort();
        tick(1, 16'h0101, 0, 0, 0);
        tick(1, 16'h0202, 1, 0, 0);
        tick(1, 16'h0303, 0, 0, 0);
        tick(1, 16'h0404, 1, 1, 0);
        checks++; if (rd_level !== 5'd2 || wr_level !== 5'd2 || drop !== 1'b1) begin errors++; $display("FAIL cmt_abort got rl %0d wl %0d d%b exp 2 2 1", rd_level, wr_level, drop); end
        tick(0, '0, 0, 0, 1);
        tick(0, '0, 0, 0, 1);
        checks++; if (rd_data !== 16'h0202 || empty !== 1'b1) begin errors++; $display("FAIL cmt_abort_drain got %h empty %b exp 0202 1", rd_data, empty); end
    endtask

    task automatic test_random();
        int ncommit = 0;
        for (int c = 0; c < 3000; c++) begin
            bit we, wc, wa, re;
            we = ($urandom_range(99) < 70);
            wc = ($urandom_range(99) < 15);
            wa = ($urandom_range(99) < 2);
            re = ($urandom_range(99) < 60);
            if (wc && !wa) ncommit += fq.size() + int'(we);
            tick(we, DW'($urandom), wc, wa, re);
            checks++;
            if (rd_valid !== m_valid || rd_data !== m_rdata || rd_perr !== 1'b0) begin
                errors++; $display("FAIL rand_read c%0d got v%b %h p%b exp v%b %h p0", c, rd_valid, rd_data, rd_perr, m_valid, m_rdata);
            end
            checks++;
            if (empty !== (cq.size() == 0) || full !== ((cq.size() + fq.size()) == DEPTH)
                || almost_full !== ((DEPTH - cq.size() - fq.size()) <= AFM)) begin
                errors++; $display("FAIL rand_flags c%0d got e%b f%b af%b rl %0d wl %0d", c, empty, full, almost_full, cq.size(), cq.size() + fq.size());
            end
            checks++;
            if (rd_level !== 5'(cq.size()) || wr_level !== 5'(cq.size() + fq.size()) || drop !== m_drop) begin
                errors++; $display("FAIL rand_level c%0d got rl %0d wl %0d d%b exp %0d %0d %b", c, rd_level, wr_level, drop, cq.size(), cq.size() + fq.size(), m_drop);
            end
        end
        checks++; if (ncommit < 600) begin errors++; $display("FAIL rand_volume got %0d exp >=600", ncommit); end
    endtask

    task automatic test_parity();
        tick(1, 16'h00F0, 0, 0, 0);
        tick(1, 16'h0F0F, 1, 0, 0);
`ifdef ETH_PKT_FIFO_PARITY_EN
        u_dut.u_ram.mem_q[0][DW] = ~u_dut.u_ram.mem_q[0][DW];
        tick(0, '0, 0, 0, 1);
        checks++; if (rd_perr !== 1'b1 || rd_data !== 16'h00F0) begin errors++; $display("FAIL parity_bad got p%b %h exp p1 00f0", rd_perr, rd_data); end
`else
        tick(0, '0, 0, 0, 1);
        checks++; if (rd_perr !== 1'b0 || rd_data !== 16'h00F0) begin errors++; $display("FAIL parity_off got p%b %h exp p0 00f0", rd_perr, rd_data); end
`endif
        tick(0, '0, 0, 0, 1);
        checks++; if (rd_perr !== 1'b0 || rd_data !== 16'h0F0F) begin errors++; $display("FAIL parity_good got p%b %h exp p0 0f0f", rd_perr, rd_data); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_abort();
        test_overflow();
        test_commit_abort();
        test_random();
        test_reset();
        test_parity();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
